// File: rtl/minute_gen.sv
// Seconds generator: a CLK_HZ prescaler produces a one-cycle `second` pulse per elapsed
// second, and a 0..59 seconds count produces a one-cycle `minute` pulse on its rollover.
module minute_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  input  logic       load,
  input  logic [5:0] load_sec,
  output logic       second,
  output logic       minute,
  output logic [5:0] r_second
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc, presc_nxt;
  logic [5:0]    sec_nxt;
  logic          second_nxt, minute_nxt;

  // Priority: clear > load > counting; pulses only ever come from a counting tick.
  always_comb begin
    presc_nxt  = presc;
    sec_nxt    = r_second;
    second_nxt = 1'b0;
    minute_nxt = 1'b0;
    if (clear) begin
      presc_nxt = '0;
      sec_nxt   = 6'd0;
    end else if (load) begin
      presc_nxt = '0;
      if (load_sec <= 6'd59) sec_nxt = load_sec;
    end else if (run) begin
      if (presc == LAST) begin
        presc_nxt  = '0;
        second_nxt = 1'b1;
        if (r_second == 6'd59) begin
          sec_nxt    = 6'd0;
          minute_nxt = 1'b1;
        end else begin
          sec_nxt = 6'(r_second + 6'd1);
        end
      end else begin
        presc_nxt = PW'(presc + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      r_second <= 6'd0;
      second   <= 1'b0;
      minute   <= 1'b0;
    end else begin
      presc    <= presc_nxt;
      r_second <= sec_nxt;
      second   <= second_nxt;
      minute   <= minute_nxt;
    end
  end

endmodule

// File: tb/tb_minute_gen.sv
// Directed bench for minute_gen at CLK_HZ=4: reset, rollover, stall, load, priority and
// a behavioural hour counter fed by the minute pulse.
module tb_minute_gen;

  logic       clk = 1'b0;
  logic       rst_n, run, clear, load;
  logic [5:0] load_sec;
  logic       second, minute;
  logic [5:0] r_second;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  minute_gen #(.CLK_HZ(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .load(load),
    .load_sec(load_sec), .second(second), .minute(minute), .r_second(r_second)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural hour counter driven by the minute pulse
  int min_cnt = 0;
  int hour    = 0;
  always @(posedge clk) begin
    if (minute) begin
      if (min_cnt == 59) begin
        min_cnt <= 0;
        hour    <= hour + 1;
      end else begin
        min_cnt <= min_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks: advance one edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // edges until the next second pulse, 0 if none within limit
  task automatic wait_second(input int limit, output int edges);
    bit found;
    edges = 0;
    found = 0;
    for (int i = 1; i <= limit; i++) begin
      if (!found) begin
        step();
        if (second) begin
          edges = i;
          found = 1;
        end
      end
    end
  endtask

  initial begin
    int n_sec, n_min, min_edge, edges, stall_pulses;
    logic [5:0] prev_sec;
    rst_n = 0; run = 0; clear = 0; load = 0; load_sec = 6'd0;

    // reset
    steps(2);
    check_eq("reset_second", second, 0);
    check_eq("reset_minute", minute, 0);
    check_eq("reset_r_second", r_second, 0);

    // rollover: 240 edges from reset, pulses every 4th edge
    rst_n = 1; run = 1;
    for (int k = 1; k <= 60; k++) exp_q.push_back(32'(4 * k));
    n_sec = 0; n_min = 0; min_edge = 0; prev_sec = 6'd0;
    for (int i = 1; i <= 240; i++) begin
      prev_sec = r_second;
      step();
      if (i == 3) check_eq("no_pulse_edge3", second, 0);
      if (i == 4) check_eq("first_tick_r_second", r_second, 1);
      if (second) begin
        n_sec++;
        if (exp_q.size() > 0) check_eq("second_edge", i, exp_q.pop_front());
        else check_eq("extra_second_pulse", 1, 0);
      end
      if (minute) begin
        n_min++;
        min_edge = i;
        check_eq("minute_prev_r_second", prev_sec, 59);
        check_eq("minute_with_second", second, 1);
      end
    end
    check_eq("rollover_seconds", n_sec, 60);
    check_eq("rollover_minutes", n_min, 1);
    check_eq("rollover_minute_edge", min_edge, 240);
    check_eq("rollover_r_second", r_second, 0);
    check_eq("rollover_queue_empty", exp_q.size(), 0);

    // stall at prescaler phase 2
    steps(2);
    run = 0;
    stall_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (second || minute) stall_pulses++;
    end
    check_eq("stall_no_pulse", stall_pulses, 0);
    check_eq("stall_hold_r_second", r_second, 0);
    run = 1;
    wait_second(10, edges);
    check_eq("stall_resume_edges", edges, 2);
    check_eq("stall_resume_r_second", r_second, 1);

    // load 58 -> minute 8 edges later
    load = 1; load_sec = 6'd58;
    step();
    load = 0;
    check_eq("load58_r_second", r_second, 58);
    check_eq("load58_no_second", second, 0);
    check_eq("load58_no_minute", minute, 0);
    wait_second(10, edges);
    check_eq("load58_first_tick", edges, 4);
    check_eq("load58_r59", r_second, 59);
    check_eq("load58_no_early_minute", minute, 0);
    wait_second(10, edges);
    check_eq("load58_second_tick", edges, 4);
    check_eq("load58_minute", minute, 1);
    check_eq("load58_wrap", r_second, 0);

    // load 59 must not pulse
    step();
    load = 1; load_sec = 6'd59;
    step();
    load = 0;
    check_eq("load59_r_second", r_second, 59);
    check_eq("load59_no_second", second, 0);
    check_eq("load59_no_minute", minute, 0);

    // load 60: r_second holds, prescaler zeroed
    steps(2);
    load = 1; load_sec = 6'd60;
    step();
    load = 0;
    check_eq("load60_hold", r_second, 59);
    check_eq("load60_no_second", second, 0);
    wait_second(10, edges);
    check_eq("load60_presc_zero", edges, 4);
    check_eq("load60_minute", minute, 1);
    check_eq("load60_wrap", r_second, 0);

    // clear beats load
    load = 1; load_sec = 6'd10;
    step();
    check_eq("load10_r_second", r_second, 10);
    steps(0);
    clear = 1; load_sec = 6'd30;
    step();
    clear = 0; load = 0;
    check_eq("clear_over_load", r_second, 0);
    check_eq("clear_no_second", second, 0);

    // reset at prescaler 3 with r_second 59
    load = 1; load_sec = 6'd59;
    step();
    load = 0;
    steps(3);
    rst_n = 0;
    step();
    check_eq("midreset_no_minute", minute, 0);
    check_eq("midreset_no_second", second, 0);
    check_eq("midreset_r_second", r_second, 0);
    rst_n = 1;
    wait_second(10, edges);
    check_eq("post_reset_first_tick", edges, 4);
    check_eq("post_reset_r_second", r_second, 1);

    // chain into hour counter
    clear = 1;
    step();
    clear = 0;
    @(negedge clk);
    min_cnt = 0; hour = 0;
    n_min = 0;
    #6;
    for (int i = 0; i < 14400; i++) begin
      step();
      if (minute) n_min++;
    end
    step();
    check_eq("chain_minutes", n_min, 60);
    check_eq("chain_hour", hour, 1);
    check_eq("chain_min_cnt", min_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
